// File: rtl/vec_mem_responder.sv
// vec_mem_responder: turns one 256-bit vector load or store into 16 sequential
// 16-bit accesses on a single-port synchronous RAM, stalling the pipeline
// while it is busy and publishing completed loads on Vmemout.
//
// state | meaning
// IDLE  | waiting for a request; stall follows req_valid
// WRITE | presenting one store lane per cycle (lane cnt)
// READ  | presenting load address cnt, capturing data for lane cnt-1
// RTAIL | capturing the last load lane and publishing Vmemout
// DONE  | one-cycle completion pulse; pipeline released, no new request taken
module vec_mem_responder #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [LANES*LANE_W-1:0] req_wdata,
  output logic                    stall,
  output logic                    done,
  output logic [LANES*LANE_W-1:0] Vmemout,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_we,
  output logic [LANE_W-1:0]       mem_wdata,
  input  logic [LANE_W-1:0]       mem_rdata
);

  localparam int CNT_W = $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, RTAIL, DONE} stateT;

  stateT state;
  stateT stateNext;

  logic [CNT_W-1:0]                cnt;
  logic                            op;
  logic [ADDR_W-1:0]               base;
  logic [ADDR_W-1:0]               laneAddr;
  logic [ADDR_W-1:0]               addrHold;
  logic [LANE_W-1:0]               wdataHold;
  logic [LANES-1:0][LANE_W-1:0]    wbuf;
  // The final lane bypasses rbuf and goes straight into Vmemout.
  logic [LANES-2:0][LANE_W-1:0]    rbuf;

  // Wraps naturally modulo 2^ADDR_W.
  assign laneAddr = base + ADDR_W'(cnt);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (req_valid) stateNext = req_we ? WRITE : READ;
      WRITE:   if (cnt == LAST_LANE) stateNext = DONE;
      READ:    if (cnt == LAST_LANE) stateNext = RTAIL;
      RTAIL:   stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Outputs; RAM address/data hold their last driven value when not accessing.
  always_comb begin
    stall     = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addrHold;
    mem_wdata = wdataHold;
    case (state)
      IDLE:  stall = req_valid & ~reset;
      WRITE: begin
        stall     = 1'b1;
        mem_we    = op;
        mem_addr  = laneAddr;
        mem_wdata = wbuf[cnt];
      end
      READ: begin
        stall    = 1'b1;
        mem_addr = laneAddr;
      end
      RTAIL:   stall = 1'b1;
      DONE:    done  = 1'b1;
      default: ;
    endcase
  end

  // Request capture, lane counter, read assembly and output hold registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base      <= '0;
      op        <= 1'b0;
      cnt       <= '0;
      wbuf      <= '0;
      rbuf      <= '0;
      Vmemout   <= '0;
      addrHold  <= '0;
      wdataHold <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            base <= req_addr;
            op   <= req_we;
            wbuf <= req_wdata;
            cnt  <= '0;
          end
        end
        WRITE: begin
          cnt       <= cnt + 1'b1;
          addrHold  <= laneAddr;
          wdataHold <= wbuf[cnt];
        end
        READ: begin
          cnt      <= cnt + 1'b1;
          addrHold <= laneAddr;
          // RAM data arrives one cycle after its address.
          if (cnt != '0) rbuf[cnt - 1'b1] <= mem_rdata;
        end
        RTAIL:   Vmemout <= {mem_rdata, rbuf};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mem_responder.sv
// Testbench for vec_mem_responder: a RAM model driven by the DUT, a
// transaction-level reference model checked every cycle, and directed
// scenarios with literal expectations.
module tb_vec_mem_responder;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_we = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [255:0] req_wdata = '0;
  logic         stall;
  logic         done;
  logic [255:0] Vmemout;
  logic [31:0]  mem_addr;
  logic         mem_we;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata = '0;

  vec_mem_responder dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .Vmemout(Vmemout),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatched = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RAM contents seen by the DUT, and the reference model's view of memory.
  logic [15:0] ram    [bit [31:0]];
  logic [15:0] refMem [bit [31:0]];

  function automatic logic [15:0] dflt(input logic [31:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  function automatic logic [15:0] ramRd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction

  function automatic logic [15:0] refRd(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : dflt(a);
  endfunction

  function automatic logic [255:0] mkVec(input logic [15:0] first);
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[16*i +: 16] = first + 16'(i);
    return v;
  endfunction

  // Single-port synchronous RAM: read data valid the cycle after the address.
  always @(posedge clk) begin
    mem_rdata <= ramRd(mem_addr);
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  int weCount = 0;
  int doneCount = 0;
  always @(negedge clk) begin
    if (mem_we) weCount++;
    if (done) doneCount++;
  end

  // Reference model: a request accepted in phase 0 presents lane k in
  // phase k+1; stores finish in phase 17, loads in phase 18.
  bit           busy = 0;
  int           ph = 0;
  bit           mOp = 0;
  logic [31:0]  mBase = '0;
  logic [255:0] mData = '0;
  logic [255:0] pendV = '0;
  logic [255:0] expV = '0;
  logic [31:0]  holdA = '0;
  logic [15:0]  holdD = '0;

  always @(negedge clk) begin : model
    logic        eStall, eDone, eWe;
    logic [31:0] eAddr;
    logic [15:0] eWd;
    int          lastPh;
    if (reset) begin
      busy  = 0;
      expV  = '0;
      holdA = '0;
      holdD = '0;
      chk("rst_stall", stall, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 16'h0);
      chk("rst_Vmemout", Vmemout, 256'h0);
    end else begin
      if (!busy && req_valid) begin
        busy  = 1;
        ph    = 0;
        mOp   = req_we;
        mBase = req_addr;
        mData = req_wdata;
        if (!req_we)
          for (int i = 0; i < 16; i++) pendV[16*i +: 16] = refRd(req_addr + 32'(i));
      end
      eStall = 0; eDone = 0; eWe = 0; eAddr = holdA; eWd = holdD; lastPh = 0;
      if (busy) begin
        lastPh = mOp ? 17 : 18;
        eStall = (ph < lastPh);
        if (ph >= 1 && ph <= 16) begin
          eAddr = mBase + 32'(ph - 1);
          holdA = eAddr;
          if (mOp) begin
            eWe   = 1;
            eWd   = mData[16*(ph-1) +: 16];
            holdD = eWd;
            refMem[eAddr] = eWd;
          end
        end
        if (ph == lastPh) begin
          eDone = 1;
          if (!mOp) expV = pendV;
        end
      end
      chk("stall", stall, eStall);
      chk("done", done, eDone);
      chk("mem_we", mem_we, eWe);
      chk("mem_addr", mem_addr, eAddr);
      chk("mem_wdata", mem_wdata, eWd);
      chk("Vmemout", Vmemout, expV);
      if (busy) begin
        if (ph == lastPh) busy = 0;
        else ph++;
      end
    end
  end

  // Presents a request at posedge+1 and returns cycles until done (bounded).
  task automatic doReq(input logic we, input logic [31:0] a, input logic [255:0] d,
                       input int dropAt, input bit keepValid, output int lat);
    int c;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    weCount   = 0;
    doneCount = 0;
    lat = -1;
    c = 0;
    while (c < 40) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
      c++;
      if (c == dropAt) req_valid = 1'b0;
    end
    if (lat < 0) $display("FAIL request_timeout: got no done expected done within 40 cycles");
    @(posedge clk); #1;
    if (!keepValid) req_valid = 1'b0;
  endtask

  initial begin
    int lat;
    logic [255:0] mixV;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stall", stall, 1'b0);
    chk("reset_Vmemout", Vmemout, 256'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Store then load at 0x100.
    doReq(1'b1, 32'h100, mkVec(16'h1000), 0, 0, lat);
    chk("store_latency", lat, 17);
    chk("store_we_cycles", weCount, 16);
    chk("ram_100", ramRd(32'h100), 16'h1000);
    chk("ram_10F", ramRd(32'h10F), 16'h100F);
    doReq(1'b0, 32'h100, '0, 0, 0, lat);
    chk("load_latency", lat, 18);
    chk("load_vector", Vmemout, mkVec(16'h1000));

    // Address wrap-around.
    doReq(1'b1, 32'hFFFF_FFF8, mkVec(16'h3000), 0, 0, lat);
    chk("wrap_store_latency", lat, 17);
    chk("ram_FFFFFFFF", ramRd(32'hFFFF_FFFF), 16'h3007);
    chk("ram_0", ramRd(32'h0), 16'h3008);
    chk("ram_7", ramRd(32'h7), 16'h300F);
    doReq(1'b0, 32'hFFFF_FFF8, '0, 0, 0, lat);
    chk("wrap_load_vector", Vmemout, mkVec(16'h3000));

    // Reset right after the lane-5 write of a store.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h100; req_wdata = mkVec(16'h2000);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("midreset_mem_we", mem_we, 1'b0);
    chk("midreset_stall", stall, 1'b0);
    chk("midreset_done", done, 1'b0);
    chk("midreset_Vmemout", Vmemout, 256'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ram_100_new", ramRd(32'h100), 16'h2000);
    chk("ram_105_new", ramRd(32'h105), 16'h2005);
    chk("ram_106_old", ramRd(32'h106), 16'h1006);

    // Load whose request is withdrawn at cycle 3.
    for (int i = 0; i < 16; i++) mixV[16*i +: 16] = (i < 6) ? 16'h2000 + 16'(i) : 16'h1000 + 16'(i);
    doReq(1'b0, 32'h100, '0, 3, 0, lat);
    chk("withdrawn_latency", lat, 18);
    chk("withdrawn_vector", Vmemout, mixV);
    repeat (4) @(posedge clk);
    #1;
    chk("withdrawn_done_once", doneCount, 1);

    // Back-to-back: request held valid through DONE, load follows at once.
    doReq(1'b1, 32'h200, mkVec(16'h4000), 0, 1, lat);
    chk("b2b_store_latency", lat, 17);
    doReq(1'b0, 32'h200, '0, 0, 0, lat);
    chk("b2b_load_latency", lat, 18);
    chk("b2b_load_we_cycles", weCount, 0);
    chk("b2b_load_vector", Vmemout, mkVec(16'h4000));

    repeat (5) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
